count_checker: RTL and testbench
================================

# count_checker

Sequence checker that consumes the 4-bit free-running count stream produced by the team's up-counter and verifies that each sampled value is the previous one plus one, modulo 2^WIDTH. It acquires lock after a run of correct samples, flags mismatches while locked, drops lock after repeated misses, and keeps a saturating error tally. It sits on the observer side of any counter output, as a reusable self-check block for the counter demo and its benches.

## Interface
Parameters:
- WIDTH, 4, width of the checked count
- LOCK_LEN, 3, consecutive correct samples required to lock (legal range 2..15)
- MAX_ERR, 2, consecutive mismatches while locked before lock is lost (legal range 1..15)
- ERR_CNT_W, 8, width of the saturating error counter

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- clr  in  1  synchronous clear: same effect as reset
- count_valid  in  1  count_in is sampled this cycle
- count_in  in  WIDTH  observed count value
- locked  out  1  level: checker is tracking the sequence
- err  out  1  one-cycle pulse: mismatch while locked
- lock_lost  out  1  one-cycle pulse: lock dropped
- expected  out  WIDTH  predicted next count value
- err_count  out  ERR_CNT_W  total mismatches while locked, saturating at all-ones

## Operation
- FSM states: IDLE, ACQUIRE, LOCKED. Internal counters: run (consecutive correct samples, first sample counts as 1), miss (consecutive locked mismatches).
- All arithmetic on expected is modulo 2^WIDTH: expected 4'hF followed by count_in 4'h0 is a match.
- count_valid low: no state, counter or output change (err, lock_lost still return to 0).
- IDLE, valid sample: expected <= count_in+1, run <= 1, go ACQUIRE.
- ACQUIRE, valid match: run <= run+1, expected <= count_in+1; if run+1 == LOCK_LEN go LOCKED, miss <= 0.
- ACQUIRE, valid mismatch: resync, run <= 1, expected <= count_in+1; no err, err_count unchanged.
- LOCKED, valid match: expected <= expected+1, miss <= 0.
- LOCKED, valid mismatch: err pulse, err_count increments unless saturated, expected <= expected+1 (flywheel), miss <= miss+1. If miss+1 == MAX_ERR: lock_lost pulse, locked drops, go ACQUIRE with run <= 1, expected <= count_in+1, miss <= 0.
- The final, lock-losing mismatch also pulses err and counts.
- locked = (state == LOCKED).

## Timing
- Reset/clr values: state IDLE, locked 0, err 0, lock_lost 0, expected 0, err_count 0, run 0, miss 0.
- rst_n low has priority over clr; clr has priority over count_valid, and a sample coinciding with clr is discarded.
- All outputs registered. Response to a sample appears after the rising edge that samples it (latency 1 cycle); err and lock_lost high for exactly that one cycle.
- locked rises on the edge sampling the LOCK_LEN-th consecutive correct value; it falls on the edge sampling the MAX_ERR-th consecutive mismatch.
- Upstream counter reset mid-stream (count jumps to 0): treated as an ordinary mismatch; no special handling.
- err_count at all-ones stays at all-ones; err still pulses.

## Structure
- Package count_checker_pkg: state encoding constants (IDLE=2'd0, ACQUIRE=2'd1, LOCKED=2'd2) and the run/miss counter width constant (4 bits).
- One sub-module: sat_counter (parameterised width, inc and clr inputs, synchronous active-low reset) for err_count.
- FSM, run/miss counters and expected register live in count_checker.

## Test plan
- Reset, then valid counts 5,6,7 -> locked rises after the 7 sample; expected = 8; err never pulses.
- Locked, feed E,F,0,1 -> wrap accepted, no err, expected = 2 after 1.
- Locked at expected 3, feed 9 then 4 -> one err pulse, err_count = 1, miss cleared, locked stays 1.
- Locked at expected 3, feed 9, A -> err on both, lock_lost pulses with the A sample, locked 0, err_count = 2, state ACQUIRE with expected B; then B,C -> relocked.
- Locked, count_valid low for 10 cycles -> all outputs held; then the expected value resumes the match.
- err_count at 8'hFF plus another mismatch -> stays 8'hFF, err pulses; clr asserted with count_valid high -> all outputs return to reset values and the sample is ignored.

Source files
------------

// File: rtl/count_checker_pkg.sv
// count_checker_pkg: shared types and constants for the count stream checker.
//   state_t : checker FSM state (IDLE, ACQUIRE, LOCKED)
//   CNT_W   : width of the run / miss counters inside the checker
package count_checker_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/count_checker_if.sv
// count_checker_if: bundle between a count observer and the count checker.
//   master : drives count_valid / count_in, observes checker status
//   slave  : the checker; samples the count, drives locked / err / lock_lost /
//            expected / err_count
interface count_checker_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  logic                 count_valid;
  logic [WIDTH-1:0]     count_in;
  logic                 locked;
  logic                 err;
  logic                 lock_lost;
  logic [WIDTH-1:0]     expected;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output count_valid, count_in,
    input  locked, err, lock_lost, expected, err_count
  );

  modport slave (
    input  count_valid, count_in,
    output locked, err, lock_lost, expected, err_count
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   clr   : synchronous clear (same effect as reset)
//   inc   : increment request, ignored once saturated
//   count : current value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/count_checker.sv
// count_checker: verifies that each sampled count is the previous one plus one
// (mod 2^WIDTH). Locks after LOCK_LEN consecutive correct samples, pulses err on
// each mismatch while locked, drops lock (lock_lost pulse) after MAX_ERR
// consecutive locked mismatches, and keeps a saturating tally of locked errors.
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : synchronous clear, same effect as reset, discards a coincident sample
//   bus        : count_checker_if slave (count_valid, count_in in; status out)
module count_checker
  import count_checker_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LOCK_LEN  = 3,
  parameter int MAX_ERR   = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  count_checker_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] run;
  logic [CNT_W-1:0] miss;
  logic [WIDTH-1:0] expected;
  logic             err;
  logic             lock_lost;
  logic             match;
  logic [CNT_W-1:0] run_nxt;
  logic [CNT_W-1:0] miss_nxt;

  assign match    = (bus.count_in == expected);
  assign run_nxt  = run + CNT_W'(1);
  assign miss_nxt = miss + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state     <= IDLE;
      run       <= '0;
      miss      <= '0;
      expected  <= '0;
      err       <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      err       <= 1'b0;
      lock_lost <= 1'b0;
      if (bus.count_valid) begin
        case (state)
          IDLE: begin
            expected <= bus.count_in + WIDTH'(1);
            run      <= CNT_W'(1);
            state    <= ACQUIRE;
          end
          ACQUIRE: begin
            // Match or not, resynchronise on the observed value.
            expected <= bus.count_in + WIDTH'(1);
            if (match) begin
              run <= run_nxt;
              if (run_nxt == CNT_W'(LOCK_LEN)) begin
                state <= LOCKED;
                miss  <= '0;
              end
            end else begin
              run <= CNT_W'(1);
            end
          end
          LOCKED: begin
            if (match) begin
              expected <= expected + WIDTH'(1);
              miss     <= '0;
            end else begin
              err <= 1'b1;
              if (miss_nxt == CNT_W'(MAX_ERR)) begin
                lock_lost <= 1'b1;
                state     <= ACQUIRE;
                run       <= CNT_W'(1);
                expected  <= bus.count_in + WIDTH'(1);
                miss      <= '0;
              end else begin
                // Flywheel: keep predicting from our own sequence.
                expected <= expected + WIDTH'(1);
                miss     <= miss_nxt;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (bus.count_valid && (state == LOCKED) && !match),
    .count (bus.err_count)
  );

  assign bus.locked    = (state == LOCKED);
  assign bus.err       = err;
  assign bus.lock_lost = lock_lost;
  assign bus.expected  = expected;

endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: directed and random stimulus for count_checker, checked
// every cycle against a behavioural model of the sequence-checking rules.
module tb_count_checker;

  localparam int WIDTH     = 4;
  localparam int LOCK_LEN  = 3;
  localparam int MAX_ERR   = 2;
  localparam int ERR_CNT_W = 8;
  localparam int MODV      = 1 << WIDTH;
  localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  int checks = 0;
  int errors = 0;

  count_checker_if #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) bus ();

  count_checker #(
    .WIDTH     (WIDTH),
    .LOCK_LEN  (LOCK_LEN),
    .MAX_ERR   (MAX_ERR),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: tracking mode, predicted value and tallies as plain ints.
  bit m_synced;   // at least one sample seen since reset
  bit m_locked;
  int m_exp;
  int m_good;     // consecutive agreeing samples while acquiring
  int m_bad;      // consecutive locked disagreements
  int m_errs;
  bit m_err;
  bit m_lost;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_synced = 0; m_locked = 0; m_exp = 0; m_good = 0; m_bad = 0;
    m_errs = 0; m_err = 0; m_lost = 0;
  endtask

  task automatic model_sample(input bit v, input int c, input bit cl);
    if (!rst_n || cl) begin
      model_reset();
      return;
    end
    m_err = 0;
    m_lost = 0;
    if (!v) return;
    if (!m_synced) begin
      m_synced = 1;
      m_good = 1;
      m_exp = (c + 1) % MODV;
    end else if (!m_locked) begin
      m_good = (c == m_exp) ? m_good + 1 : 1;
      m_exp = (c + 1) % MODV;
      if (m_good == LOCK_LEN) begin
        m_locked = 1;
        m_bad = 0;
      end
    end else if (c == m_exp) begin
      m_bad = 0;
      m_exp = (m_exp + 1) % MODV;
    end else begin
      m_err = 1;
      if (m_errs < ERR_MAX) m_errs++;
      m_bad++;
      if (m_bad == MAX_ERR) begin
        m_lost = 1;
        m_locked = 0;
        m_good = 1;
        m_bad = 0;
        m_exp = (c + 1) % MODV;
      end else begin
        m_exp = (m_exp + 1) % MODV;
      end
    end
  endtask

  task automatic compare_all();
    chk("locked", bus.locked, m_locked);
    chk("err", bus.err, m_err);
    chk("lock_lost", bus.lock_lost, m_lost);
    chk("expected", bus.expected, m_exp);
    chk("err_count", bus.err_count, m_errs);
  endtask

  // Drive one cycle of stimulus, sample on the rising edge, check on the falling edge.
  task automatic step(input bit v, input int c, input bit cl);
    bus.count_valid = v;
    bus.count_in = WIDTH'(c);
    clr = cl;
    @(posedge clk);
    model_sample(v, c, cl);
    @(negedge clk);
    compare_all();
  endtask

  task automatic feed(input int c);
    step(1'b1, c, 1'b0);
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    clr = 1'b0;
    bus.count_valid = 1'b1;
    bus.count_in = 4'h7;
    model_reset();
    step(1'b1, 7, 1'b0);
    step(1'b1, 3, 1'b0);
    chk("reset_locked", bus.locked, 0);
    chk("reset_expected", bus.expected, 0);
    rst_n = 1'b1;

    // Acquire on 5,6,7.
    feed(5); feed(6);
    chk("not_yet_locked", bus.locked, 0);
    feed(7);
    chk("lock_after_7", bus.locked, 1);
    chk("expected_8", bus.expected, 8);

    // Wrap through F -> 0.
    for (int v = 8; v <= 15; v++) feed(v);
    feed(0); feed(1);
    chk("wrap_expected_2", bus.expected, 2);
    chk("wrap_no_errs", bus.err_count, 0);

    // Single miss then recovery.
    step(1'b0, 0, 1'b1);
    feed(0); feed(1); feed(2);
    feed(9);
    chk("single_err_pulse", bus.err, 1);
    feed(4);
    chk("single_err_count", bus.err_count, 1);
    chk("single_still_locked", bus.locked, 1);

    // Two misses lose lock, then relock on B,C.
    step(1'b0, 0, 1'b1);
    feed(0); feed(1); feed(2);
    feed(9);
    feed(10);
    chk("lost_pulse", bus.lock_lost, 1);
    chk("lost_err_pulse", bus.err, 1);
    chk("lost_unlocked", bus.locked, 0);
    chk("lost_err_count", bus.err_count, 2);
    chk("lost_expected_B", bus.expected, 11);
    feed(11); feed(12);
    chk("relocked", bus.locked, 1);

    // Idle gap while locked.
    for (int i = 0; i < 10; i++) step(1'b0, $urandom_range(0, 15), 1'b0);
    chk("gap_held_expected", bus.expected, 13);
    feed(13);
    chk("gap_resume_locked", bus.locked, 1);

    // Drive err_count into saturation: alternate a miss with a correct sample.
    for (int i = 0; i < 260; i++) begin
      feed((m_exp + 5) % MODV);
      feed(m_exp);
    end
    chk("sat_count", bus.err_count, ERR_MAX);
    feed((m_exp + 7) % MODV);
    chk("sat_err_pulse", bus.err, 1);
    chk("sat_count_hold", bus.err_count, ERR_MAX);

    // clr with a coincident valid sample.
    step(1'b1, 4, 1'b1);
    chk("clr_locked", bus.locked, 0);
    chk("clr_expected", bus.expected, 0);
    chk("clr_err_count", bus.err_count, 0);
    feed(9);
    chk("clr_sample_dropped", bus.expected, 10);

    // Random stream: mostly in-sequence, with gaps, jumps and occasional clr/reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      c = ($urandom_range(0, 99) < 80) ? m_exp : int'($urandom_range(0, MODV - 1));
      step($urandom_range(0, 3) != 0, c, $urandom_range(0, 99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
